// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg
//   Shared definitions for the UART transmit scheduler:
//   - txq_state_e    : scheduler FSM states (IDLE=0, ISSUE=1, WAIT=2)
//   - default DEPTH / FRAME_CYCLES values
//   - sat_inc16      : saturating 16-bit increment used by the drop counter
package uart_tx_scheduler_pkg;

    localparam int TXQ_DEFAULT_DEPTH        = 16;
    localparam int TXQ_DEFAULT_FRAME_CYCLES = 8680;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } txq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// uart_txq_fifo
//   Synchronous DEPTH x 8 FIFO. Occupancy is held in an explicit counter,
//   full/empty decode from that counter; pointers wrap modulo DEPTH.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      write din at the tail (ignored when full)
//   pop            advance the head (ignored when empty)
//   dout           current head entry (combinational read)
//   count          occupied entries, $clog2(DEPTH)+1 bits
//   full, empty    count==DEPTH / count==0
module uart_txq_fifo
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DEPTH = TXQ_DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array; data needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Queues bytes stored by the CPU to the UART address and hands them to the
//   uart transmitter one frame at a time, pacing issues with a frame-time
//   counter because the uart has no busy indication.
//   Optional macro UART_TXQ_STALL_EN: when defined, a store to a full queue
//   raises stall_req (combinational) so the pipeline replays it; when
//   undefined, stall_req is tied 0 and such bytes are dropped and counted.
// Ports:
//   sysclk, cpu_resetn  clock, asynchronous active-low reset
//   st_valid, st_data   store strobe and byte from the memory stage
//   stall_req           pipeline hold request (stall build only)
//   uart_wr_o           one-cycle start strobe to the uart
//   uart_dat_o          byte to the uart, held between frames
//   q_count/q_full/q_empty  queue occupancy
//   tx_active           a frame is in flight (FSM not IDLE)
//   drop_cnt            saturating count of bytes lost on a full queue
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int DEPTH        = TXQ_DEFAULT_DEPTH,
    parameter int FRAME_CYCLES = TXQ_DEFAULT_FRAME_CYCLES
) (
    input  logic                   sysclk,
    input  logic                   cpu_resetn,
    input  logic                   st_valid,
    input  logic [7:0]             st_data,
    output logic                   stall_req,
    output logic                   uart_wr_o,
    output logic [7:0]             uart_dat_o,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   q_full,
    output logic                   q_empty,
    output logic                   tx_active,
    output logic [15:0]            drop_cnt
);

    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    txq_state_e       state_r;
    txq_state_e       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic             uart_wr_r;
    logic [7:0]       uart_dat_r;
    logic [15:0]      drop_r;
    logic [15:0]      drop_nx_s;
    logic             push_s;
    logic             pop_s;
    logic             stall_s;
    logic [7:0]       head_s;

    uart_txq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (cpu_resetn),
        .push  (push_s),
        .pop   (pop_s),
        .din   (st_data),
        .dout  (head_s),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    assign stall_req  = stall_s;
    assign uart_wr_o  = uart_wr_r;
    assign uart_dat_o = uart_dat_r;
    assign drop_cnt   = drop_r;
    assign tx_active  = (state_r != ST_IDLE);

    // Store acceptance: stall or drop when the queue is full.
    always_comb begin
        push_s    = 1'b0;
        stall_s   = 1'b0;
        drop_nx_s = drop_r;
`ifdef UART_TXQ_STALL_EN
        push_s  = st_valid && !q_full;
        stall_s = st_valid && q_full;
`else
        push_s  = st_valid && !q_full;
        if (st_valid && q_full) begin
            drop_nx_s = sat_inc16(drop_r);
        end else begin
            drop_nx_s = drop_r;
        end
`endif
    end

    // Issue FSM. WAIT leaves when the counter steps down to zero so that
    // IDLE+ISSUE+WAIT together span FRAME_CYCLES+1 cycles between strobes.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_nx_s   = CNT_LOAD;
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nx_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                cnt_nx_s   = {CNT_W{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, frame counter, registered uart outputs and drop counter.
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            uart_wr_r  <= 1'b0;
            uart_dat_r <= 8'h00;
            drop_r     <= 16'h0000;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            uart_wr_r <= (state_nx_s == ST_ISSUE);
            drop_r    <= drop_nx_s;
            if (pop_s) begin
                uart_dat_r <= head_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler with DEPTH=4, FRAME_CYCLES=20.
//   Inputs are driven and outputs sampled on the falling clock edge. A
//   monitor logs each uart strobe (cycle, byte) for the scenario tasks.
//   Builds with or without UART_TXQ_STALL_EN.
module tb_uart_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int FC    = 20;

    logic        sysclk;
    logic        cpu_resetn;
    logic        st_valid;
    logic [7:0]  st_data;
    logic        stall_req;
    logic        uart_wr_o;
    logic [7:0]  uart_dat_o;
    logic [2:0]  q_count;
    logic        q_full;
    logic        q_empty;
    logic        tx_active;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int peak   = 0;
    int s_cyc[$];
    logic [7:0] s_dat[$];

    uart_tx_scheduler #(
        .DEPTH        (DEPTH),
        .FRAME_CYCLES (FC)
    ) dut (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .st_valid   (st_valid),
        .st_data    (st_data),
        .stall_req  (stall_req),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .q_count    (q_count),
        .q_full     (q_full),
        .q_empty    (q_empty),
        .tx_active  (tx_active),
        .drop_cnt   (drop_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (cpu_resetn === 1'b1) begin
            if (uart_wr_o === 1'b1) begin
                s_cyc.push_back(cyc);
                s_dat.push_back(uart_dat_o);
            end
            if (int'(q_count) > peak) peak = int'(q_count);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge sysclk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (!(q_empty === 1'b1 && tx_active === 1'b0) && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        checks++;
        if (k >= budget) begin
            errors++;
            $display("FAIL %s_idle_timeout: still busy after %0d cycles, expected idle", name, k);
        end
    endtask

    task automatic clear_log();
        s_cyc.delete();
        s_dat.delete();
        peak = 0;
    endtask

    task automatic test_reset();
        cpu_resetn = 1'b0;
        st_valid   = 1'b0;
        st_data    = 8'h00;
        repeat (3) @(negedge sysclk);
        checks++;
        if ({uart_wr_o, uart_dat_o, stall_req, drop_cnt, q_empty, q_full, tx_active, q_count}
            !== {1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got wr=%b dat=%h stall=%b drop=%0d empty=%b full=%b act=%b cnt=%0d, expected 0/00/0/0/1/0/0/0",
                     uart_wr_o, uart_dat_o, stall_req, drop_cnt, q_empty, q_full, tx_active, q_count);
        end
        cpu_resetn = 1'b1;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_single();
        int c;
        clear_log();
        c = cyc;
        st_valid = 1'b1;
        st_data  = 8'h41;
        @(negedge sysclk);
        st_valid = 1'b0;
        st_data  = 8'hFF;
        checks++;
        if (q_count !== 3'd1 || uart_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL single_push: got cnt=%0d wr=%b, expected cnt=1 wr=0", q_count, uart_wr_o);
        end
        @(negedge sysclk);
        checks++;
        if (uart_wr_o !== 1'b1 || uart_dat_o !== 8'h41 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL single_strobe: got wr=%b dat=%h cnt=%0d, expected wr=1 dat=41 cnt=0", uart_wr_o, uart_dat_o, q_count);
        end
        at_cycle(c + 3);
        checks++;
        if (uart_wr_o !== 1'b0 || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL single_strobe_width: got wr=%b act=%b, expected wr=0 act=1", uart_wr_o, tx_active);
        end
        at_cycle(c + 21);
        checks++;
        if (tx_active !== 1'b1) begin
            errors++;
            $display("FAIL single_active_hold: got act=%b, expected 1", tx_active);
        end
        at_cycle(c + 23);
        checks++;
        if (tx_active !== 1'b0 || uart_dat_o !== 8'h41) begin
            errors++;
            $display("FAIL single_done: got act=%b dat=%h, expected act=0 dat=41", tx_active, uart_dat_o);
        end
        checks++;
        if (s_dat.size() !== 1) begin
            errors++;
            $display("FAIL single_strobe_count: got %0d, expected 1", s_dat.size());
        end
    endtask

    task automatic test_burst();
        int c;
        logic [7:0] exp_d;
        clear_log();
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_data  = 8'h31 + 8'(i);
            @(negedge sysclk);
        end
        st_valid = 1'b0;
        wait_idle(200, "burst");
        checks++;
        if (s_dat.size() !== 3) begin
            errors++;
            $display("FAIL burst_count: got %0d strobes, expected 3", s_dat.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_d = 8'h31 + 8'(i);
                checks++;
                if (s_dat[i] !== exp_d || s_cyc[i] !== c + 2 + (FC + 1) * i) begin
                    errors++;
                    $display("FAIL burst_strobe%0d: got dat=%h cyc=%0d, expected dat=%h cyc=%0d",
                             i, s_dat[i], s_cyc[i] - c, exp_d, 2 + (FC + 1) * i);
                end
            end
        end
        checks++;
        if (peak !== 2) begin
            errors++;
            $display("FAIL burst_peak: got q_count peak %0d, expected 2", peak);
        end
    endtask

    task automatic test_overflow();
        int n_exp;
        int k;
        logic full_seen;
        logic stall_seen;
        logic [7:0] exp_d;
        clear_log();
        full_seen  = 1'b0;
        stall_seen = 1'b0;
`ifdef UART_TXQ_STALL_EN
        n_exp = 6;
        for (int i = 0; i < 6; i++) begin
            st_valid = 1'b1;
            st_data  = 8'h50 + 8'(i);
            #1;
            k = 0;
            while (stall_req === 1'b1 && k < 100) begin
                stall_seen = 1'b1;
                if (q_full === 1'b1) full_seen = 1'b1;
                @(negedge sysclk);
                #1;
                k++;
            end
            @(negedge sysclk);
        end
        st_valid = 1'b0;
        checks++;
        if (stall_seen !== 1'b1 || full_seen !== 1'b1) begin
            errors++;
            $display("FAIL ovf_stall_seen: got stall=%b full=%b, expected 1/1", stall_seen, full_seen);
        end
        @(negedge sysclk);
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ovf_drop: got drop_cnt=%0d, expected 0", drop_cnt);
        end
`else
        n_exp = 5;
        for (int i = 0; i < 6; i++) begin
            if (i == 5 && q_full === 1'b1) full_seen = 1'b1;
            st_valid = 1'b1;
            st_data  = 8'h50 + 8'(i);
            #1;
            if (stall_req !== 1'b0) stall_seen = 1'b1;
            @(negedge sysclk);
        end
        st_valid = 1'b0;
        checks++;
        if (full_seen !== 1'b1 || stall_seen !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full_seen: got full=%b stall=%b, expected 1/0", full_seen, stall_seen);
        end
        @(negedge sysclk);
        checks++;
        if (drop_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ovf_drop: got drop_cnt=%0d, expected 1", drop_cnt);
        end
`endif
        wait_idle(400, "ovf");
        checks++;
        if (s_dat.size() !== n_exp) begin
            errors++;
            $display("FAIL ovf_count: got %0d strobes, expected %0d", s_dat.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                exp_d = 8'h50 + 8'(i);
                checks++;
                if (s_dat[i] !== exp_d) begin
                    errors++;
                    $display("FAIL ovf_data%0d: got %h, expected %h", i, s_dat[i], exp_d);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int c;
        logic [7:0] exp_d;
        clear_log();
        for (int i = 0; i < 10; i++) begin
            c = cyc;
            st_valid = 1'b1;
            st_data  = 8'hA0 + 8'(i);
            @(negedge sysclk);
            st_valid = 1'b0;
            at_cycle(c + FC + 1);
        end
        wait_idle(100, "wrap");
        checks++;
        if (s_dat.size() !== 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d strobes, expected 10", s_dat.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                exp_d = 8'hA0 + 8'(i);
                checks++;
                if (s_dat[i] !== exp_d) begin
                    errors++;
                    $display("FAIL wrap_data%0d: got %h, expected %h", i, s_dat[i], exp_d);
                end
            end
        end
        checks++;
        if (q_empty !== 1'b1 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_empty: got empty=%b cnt=%0d, expected 1/0", q_empty, q_count);
        end
    endtask

    task automatic test_reset_in_wait();
        int c;
        clear_log();
        c = cyc;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_data  = 8'hC0 + 8'(i);
            @(negedge sysclk);
        end
        st_valid = 1'b0;
        at_cycle(c + 5);
        checks++;
        if (tx_active !== 1'b1 || q_count !== 3'd2) begin
            errors++;
            $display("FAIL rst_wait_pre: got act=%b cnt=%0d, expected act=1 cnt=2", tx_active, q_count);
        end
        cpu_resetn = 1'b0;
        @(negedge sysclk);
        checks++;
        if (q_empty !== 1'b1 || tx_active !== 1'b0 || uart_wr_o !== 1'b0 || q_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_wait_clear: got empty=%b act=%b wr=%b cnt=%0d, expected 1/0/0/0",
                     q_empty, tx_active, uart_wr_o, q_count);
        end
        cpu_resetn = 1'b1;
        clear_log();
        repeat (3 * (FC + 1)) @(negedge sysclk);
        checks++;
        if (s_dat.size() !== 0 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_quiet: got %0d strobes act=%b after release, expected 0/0", s_dat.size(), tx_active);
        end
    endtask

    initial begin
        cpu_resetn = 1'b0;
        st_valid   = 1'b0;
        st_data    = 8'h00;
        @(negedge sysclk);
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
